inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_if.sv | 28 ++
 rtl/inst_queue.sv | 104 ++++++++++
 tb/tb_inst_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for inst_queue: push side, pop side and queue status.
// master drives push/pop/flush and the fetched word; slave is the queue itself.
interface inst_queue_if #(
    parameter int DEPTH = 4
);
    logic                       push;
    logic [15:0]                instr_in;
    logic [15:0]                pc_plus_in;
    logic                       flush;
    logic                       pop;
    logic [15:0]                instr_out;
    logic [15:0]                pc_plus_out;
    logic                       out_valid;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       err;

    modport master (
        output push, instr_in, pc_plus_in, flush, pop,
        input  instr_out, pc_plus_out, out_valid, full, empty, count, err
    );

    modport slave (
        input  push, instr_in, pc_plus_in, flush, pop,
        output instr_out, pc_plus_out, out_valid, full, empty, count, err
    );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode; head is combinational, 1-cycle push-to-valid
// (0 cycles with INST_QUEUE_BYPASS_EN defined). Pushes into a full queue without pop are dropped
// and flagged on err for one cycle; fetch must stall on full. Flush clears the queue at the next edge.
module inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] NOP_WORD = 16'h0800
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  q_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          mem_we;
    logic          is_full, is_empty;
    logic          push_ok, pop_ok, bypass_take;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        bypass_take = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        bypass_take = is_empty && q_if.push && q_if.pop && !q_if.flush;
`endif
        // A pop on a full queue frees the slot the same cycle, so the push still fits.
        push_ok = q_if.push && (!is_full || q_if.pop);
        pop_ok  = q_if.pop && !is_empty;

        if (q_if.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!bypass_take) begin
            if (push_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CW'(1);
            end
            err_d = q_if.push && is_full && !q_if.pop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: out_valid masks it whenever count is zero.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {q_if.instr_in, q_if.pc_plus_in};
        end
    end

    always_comb begin
        logic [31:0] head;
        logic        vld;
        head = mem_q[rd_ptr_q];
        vld  = !is_empty;
`ifdef INST_QUEUE_BYPASS_EN
        if (is_empty && q_if.push && !q_if.flush) begin
            head = {q_if.instr_in, q_if.pc_plus_in};
            vld  = 1'b1;
        end
`endif
        q_if.out_valid   = vld;
        q_if.instr_out   = vld ? head[31:16] : NOP_WORD;
        q_if.pc_plus_out = vld ? head[15:0]  : 16'h0000;
    end

    assign q_if.full  = is_full;
    assign q_if.empty = is_empty;
    assign q_if.count = count_q;
    assign q_if.err   = err_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed vector bench for inst_queue at DEPTH=4; honours INST_QUEUE_BYPASS_EN for the bypass case.
module tb_inst_queue;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_queue_if #(.DEPTH(4)) q_if ();

    inst_queue #(.DEPTH(4), .NOP_WORD(16'h0800)) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        flush;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [2:0]  e_cnt;
        logic        e_vld;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic        e_full;
        logic        e_empty;
        logic        e_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic o, input logic f,
                         input logic [15:0] i, input logic [15:0] pc);
        q_if.push       = p;
        q_if.pop        = o;
        q_if.flush      = f;
        q_if.instr_in   = i;
        q_if.pc_plus_in = pc;
    endtask

    // Apply one cycle of inputs, then idle them so the outputs reflect stored state only.
    task automatic step(input logic p, input logic o, input logic f,
                        input logic [15:0] i, input logic [15:0] pc);
        @(negedge clk);
        drive(p, o, f, i, pc);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"},   32'(q_if.count),     32'd0);
        chk({tag, " valid"},   32'(q_if.out_valid), 32'd0);
        chk({tag, " instr"},   32'(q_if.instr_out), 32'h0800);
        chk({tag, " pc"},      32'(q_if.pc_plus_out), 32'h0);
        chk({tag, " empty"},   32'(q_if.empty),     32'd1);
        chk({tag, " full"},    32'(q_if.full),      32'd0);
        chk({tag, " err"},     32'(q_if.err),       32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          push pop fl  instr     pc        cnt vld e_instr   e_pc      fu em er
        vecs[0]  = '{1'b1,1'b0,1'b0,16'h1234,16'h0002,3'd1,1'b1,16'h1234,16'h0002,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,16'h5678,16'h0004,3'd2,1'b1,16'h1234,16'h0002,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,16'h1111,16'h0006,3'd3,1'b1,16'h1234,16'h0002,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,16'h2222,16'h0008,3'd4,1'b1,16'h1234,16'h0002,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,16'hBEEF,16'h000A,3'd4,1'b1,16'h1234,16'h0002,1'b1,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,3'd4,1'b1,16'h1234,16'h0002,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,16'hAAAA,16'h000C,3'd4,1'b1,16'h5678,16'h0004,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd3,1'b1,16'h1111,16'h0006,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd2,1'b1,16'h2222,16'h0008,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd1,1'b1,16'hAAAA,16'h000C,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd0,1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd0,1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,16'h3333,16'h0010,3'd1,1'b1,16'h3333,16'h0010,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,16'h4444,16'h0012,3'd2,1'b1,16'h3333,16'h0010,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,16'h5555,16'h0014,3'd3,1'b1,16'h3333,16'h0010,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b1,1'b1,16'h6666,16'h0018,3'd0,1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0};
        vecs[16] = '{1'b1,1'b0,1'b0,16'h7777,16'h0016,3'd1,1'b1,16'h7777,16'h0016,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd0,1'b0,16'h0800,16'h0000,1'b0,1'b1,1'b0};

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 18; v++) begin
            step(vecs[v].push, vecs[v].pop, vecs[v].flush, vecs[v].instr, vecs[v].pc);
            chk($sformatf("v%0d count", v), 32'(q_if.count),       32'(vecs[v].e_cnt));
            chk($sformatf("v%0d valid", v), 32'(q_if.out_valid),   32'(vecs[v].e_vld));
            chk($sformatf("v%0d instr", v), 32'(q_if.instr_out),   32'(vecs[v].e_instr));
            chk($sformatf("v%0d pc", v),    32'(q_if.pc_plus_out), 32'(vecs[v].e_pc));
            chk($sformatf("v%0d full", v),  32'(q_if.full),        32'(vecs[v].e_full));
            chk($sformatf("v%0d empty", v), 32'(q_if.empty),       32'(vecs[v].e_empty));
            chk($sformatf("v%0d err", v),   32'(q_if.err),         32'(vecs[v].e_err));
        end

        // Push with pop into an empty queue: same-cycle visibility depends on bypass.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h4321, 16'h0020);
        #1;
`ifdef INST_QUEUE_BYPASS_EN
        chk("byp same valid", 32'(q_if.out_valid),   32'd1);
        chk("byp same instr", 32'(q_if.instr_out),   32'h4321);
        chk("byp same pc",    32'(q_if.pc_plus_out), 32'h0020);
`else
        chk("byp same valid", 32'(q_if.out_valid),   32'd0);
        chk("byp same instr", 32'(q_if.instr_out),   32'h0800);
`endif
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
`ifdef INST_QUEUE_BYPASS_EN
        chk("byp next count", 32'(q_if.count),     32'd0);
        chk("byp next valid", 32'(q_if.out_valid), 32'd0);
`else
        chk("byp next count", 32'(q_if.count),     32'd1);
        chk("byp next instr", 32'(q_if.instr_out), 32'h4321);
`endif

        // Flush then queue three words, and drop reset between edges.
        step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h9991, 16'h0030);
        step(1'b1, 1'b0, 1'b0, 16'h9992, 16'h0032);
        step(1'b1, 1'b0, 1'b0, 16'h9993, 16'h0034);
        chk("pre-rst count", 32'(q_if.count),     32'd3);
        chk("pre-rst instr", 32'(q_if.instr_out), 32'h9991);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async rst");
        #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
